// File: rtl/discus_io_pkg.sv
// Shared constants for the discus IO bridge: register indices, STATUS/CTRL
// bit positions and the UART state encodings.
package discus_io_pkg;

    // io_address register select
    localparam logic [2:0] REG_PADDR  = 3'd0;
    localparam logic [2:0] REG_PDATA  = 3'd1;
    localparam logic [2:0] REG_DADDR  = 3'd2;
    localparam logic [2:0] REG_DDATA  = 3'd3;
    localparam logic [2:0] REG_UART   = 3'd4;
    localparam logic [2:0] REG_STATUS = 3'd5;
    localparam logic [2:0] REG_LED    = 3'd6;
    localparam logic [2:0] REG_CTRL   = 3'd7;

    // STATUS bit positions
    localparam int ST_TX_BUSY   = 0;
    localparam int ST_RX_VALID  = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_FRAME_ERR = 3;

    // CTRL bit positions
    localparam int CTRL_CPU_RESET = 0;
    localparam int CTRL_AUTOINC   = 1;

    // UART transmitter states
    localparam logic TX_IDLE = 1'b0;
    localparam logic TX_RUN  = 1'b1;

    // UART receiver states
    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

endpackage

// File: rtl/discus_uart.sv
// Byte-level 8N1 UART, LSB first. The transmitter accepts a byte on tx_start
// when idle; the receiver synchronises rxd, validates the start bit at half a
// bit, samples data mid-bit and reports a good byte or a framing error.
module discus_uart
    import discus_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
)(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tx_start,
    input  logic [7:0] tx_byte,
    output logic       tx_busy,
    output logic       txd,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       rx_strobe,
    output logic       rx_frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             r_tx_state;
    logic [CNT_W-1:0] r_tx_cnt;
    logic [3:0]       r_tx_bit;
    logic [8:0]       r_tx_shift;
    logic             r_txd;

    logic [2:0]       r_rx_sync;
    logic [1:0]       r_rx_state;
    logic [CNT_W-1:0] r_rx_cnt;
    logic [2:0]       r_rx_bit;
    logic [7:0]       r_rx_shift;
    logic [7:0]       r_rx_byte;
    logic             r_rx_strobe;
    logic             r_rx_ferr;

    logic             w_rx_bit;
    logic             w_rx_fall;

    // bit 1 is the synchronised line, bit 2 its previous value
    assign w_rx_bit  = r_rx_sync[1];
    assign w_rx_fall = r_rx_sync[2] & ~r_rx_sync[1];

    assign tx_busy      = (r_tx_state == TX_RUN);
    assign txd          = r_txd;
    assign rx_byte      = r_rx_byte;
    assign rx_strobe    = r_rx_strobe;
    assign rx_frame_err = r_rx_ferr;

    // Transmitter: start bit is driven on the accepting edge, then each bit
    // (data, then stop) holds for CLKS_PER_BIT cycles; busy drops after stop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '1;
            r_txd      <= 1'b1;
        end else if (r_tx_state == TX_IDLE) begin
            if (tx_start) begin
                r_tx_state <= TX_RUN;
                r_tx_shift <= {1'b1, tx_byte};
                r_txd      <= 1'b0;
                r_tx_cnt   <= '0;
                r_tx_bit   <= '0;
            end
        end else begin
            if (r_tx_cnt == CNT_LAST) begin
                r_tx_cnt <= '0;
                if (r_tx_bit == 4'd9) begin
                    r_tx_state <= TX_IDLE;
                end else begin
                    r_txd      <= r_tx_shift[0];
                    r_tx_shift <= {1'b1, r_tx_shift[8:1]};
                    r_tx_bit   <= r_tx_bit + 4'd1;
                end
            end else begin
                r_tx_cnt <= r_tx_cnt + CNT_W'(1);
            end
        end
    end

    // Two-stage synchroniser plus one history stage for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rx_sync <= 3'b111;
        else          r_rx_sync <= {r_rx_sync[1:0], rxd};
    end

    // Receiver: falling edge -> half-bit start check -> 8 mid-bit samples -> stop check
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_state  <= RX_IDLE;
            r_rx_cnt    <= '0;
            r_rx_bit    <= '0;
            r_rx_shift  <= '0;
            r_rx_byte   <= '0;
            r_rx_strobe <= 1'b0;
            r_rx_ferr   <= 1'b0;
        end else begin
            r_rx_strobe <= 1'b0;
            r_rx_ferr   <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (w_rx_fall) begin
                        r_rx_state <= RX_START;
                        r_rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == CNT_HALF) begin
                        r_rx_cnt <= '0;
                        r_rx_bit <= '0;
                        r_rx_state <= w_rx_bit ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == CNT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {w_rx_bit, r_rx_shift[7:1]};
                        if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
                        else                  r_rx_bit   <= r_rx_bit + 3'd1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (r_rx_cnt == CNT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= RX_IDLE;
                        if (w_rx_bit) begin
                            r_rx_byte   <= r_rx_shift;
                            r_rx_strobe <= 1'b1;
                        end else begin
                            r_rx_ferr <= 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/discus_io_bridge.sv
// Register-mapped bridge from the IO discus core to the target CPU's program
// and data RAMs, a byte UART, LEDs and the target CPU reset.
// Address registers are assumed no wider than the IO data bus.
module discus_io_bridge
    import discus_io_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int NUM_LEDS     = 4,
    parameter int CLKS_PER_BIT = 87
)(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                io_read,
    input  logic                io_write,
    input  logic [2:0]          io_address,
    input  logic [DATA_W-1:0]   io_D,
    output logic [DATA_W-1:0]   io_Q,
    output logic                prog_we,
    output logic [ADDR_W-1:0]   prog_addr,
    output logic [DATA_W-1:0]   prog_wdata,
    input  logic [DATA_W-1:0]   prog_rdata,
    output logic                data_we,
    output logic [ADDR_W-1:0]   data_addr,
    output logic [DATA_W-1:0]   data_wdata,
    input  logic [DATA_W-1:0]   data_rdata,
    input  logic                uart_rxd,
    output logic                uart_txd,
    output logic [NUM_LEDS-1:0] leds,
    output logic                cpu_reset
);

    logic [DATA_W-1:0]   r_q;
    logic [ADDR_W-1:0]   r_paddr, r_daddr;
    logic                r_prog_we, r_data_we;
    logic                r_prog_inc, r_data_inc;
    logic [DATA_W-1:0]   r_prog_wdata, r_data_wdata;
    logic [NUM_LEDS-1:0] r_leds;
    logic                r_cpu_reset, r_autoinc;
    logic                r_rx_valid, r_overrun, r_frame_err;
    logic [7:0]          r_rx_hold;

    logic                w_rd, w_rd_uart;
    logic                w_wr_pdata, w_wr_ddata, w_wr_uart, w_wr_status;
    logic                w_tx_start, w_tx_busy;
    logic [7:0]          w_rx_byte;
    logic                w_rx_strobe, w_rx_frame_err;
    logic [DATA_W-1:0]   w_rd_data;

    // a read coinciding with a write is ignored
    assign w_rd        = io_read & ~io_write;
    assign w_rd_uart   = w_rd && (io_address == REG_UART);
    assign w_wr_pdata  = io_write && (io_address == REG_PDATA);
    assign w_wr_ddata  = io_write && (io_address == REG_DDATA);
    assign w_wr_uart   = io_write && (io_address == REG_UART);
    assign w_wr_status = io_write && (io_address == REG_STATUS);
    assign w_tx_start  = w_wr_uart & ~w_tx_busy;

    assign io_Q       = r_q;
    assign prog_we    = r_prog_we;
    assign prog_addr  = r_paddr;
    assign prog_wdata = r_prog_wdata;
    assign data_we    = r_data_we;
    assign data_addr  = r_daddr;
    assign data_wdata = r_data_wdata;
    assign leds       = r_leds;
    assign cpu_reset  = r_cpu_reset;

    discus_uart #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
        .clk          (clk),
        .reset_n      (reset_n),
        .tx_start     (w_tx_start),
        .tx_byte      (io_D[7:0]),
        .tx_busy      (w_tx_busy),
        .txd          (uart_txd),
        .rxd          (uart_rxd),
        .rx_byte      (w_rx_byte),
        .rx_strobe    (w_rx_strobe),
        .rx_frame_err (w_rx_frame_err)
    );

    // Read mux; unmapped bits stay 0
    always_comb begin
        w_rd_data = '0;
        case (io_address)
            REG_PADDR:  w_rd_data[ADDR_W-1:0] = r_paddr;
            REG_PDATA:  w_rd_data = prog_rdata;
            REG_DADDR:  w_rd_data[ADDR_W-1:0] = r_daddr;
            REG_DDATA:  w_rd_data = data_rdata;
            REG_UART:   w_rd_data[7:0] = r_rx_hold;
            REG_STATUS: begin
                w_rd_data[ST_TX_BUSY]   = w_tx_busy;
                w_rd_data[ST_RX_VALID]  = r_rx_valid;
                w_rd_data[ST_OVERRUN]   = r_overrun;
                w_rd_data[ST_FRAME_ERR] = r_frame_err;
            end
            REG_LED:    w_rd_data[NUM_LEDS-1:0] = r_leds;
            default: begin
                w_rd_data[CTRL_CPU_RESET] = r_cpu_reset;
                w_rd_data[CTRL_AUTOINC]   = r_autoinc;
            end
        endcase
    end

    // Registered read data, zero whenever no read is being served
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_q <= '0;
        else          r_q <= w_rd ? w_rd_data : '0;
    end

    // RAM write pipeline: we pulses one cycle after the strobe at the current
    // address; any auto-increment lands at the end of that we cycle, so the
    // write always targets the pre-increment address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prog_we    <= 1'b0;
            r_data_we    <= 1'b0;
            r_prog_inc   <= 1'b0;
            r_data_inc   <= 1'b0;
            r_prog_wdata <= '0;
            r_data_wdata <= '0;
        end else begin
            r_prog_we  <= w_wr_pdata;
            r_data_we  <= w_wr_ddata;
            r_prog_inc <= w_wr_pdata & r_autoinc;
            r_data_inc <= w_wr_ddata & r_autoinc;
            if (w_wr_pdata) r_prog_wdata <= io_D;
            if (w_wr_ddata) r_data_wdata <= io_D;
        end
    end

    // Address, LED and control registers; an explicit address write beats a pending increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_paddr     <= '0;
            r_daddr     <= '0;
            r_leds      <= '0;
            r_cpu_reset <= 1'b1;
            r_autoinc   <= 1'b1;
        end else begin
            if (io_write && io_address == REG_PADDR) r_paddr <= io_D[ADDR_W-1:0];
            else if (r_prog_inc)                     r_paddr <= r_paddr + ADDR_W'(1);
            if (io_write && io_address == REG_DADDR) r_daddr <= io_D[ADDR_W-1:0];
            else if (r_data_inc)                     r_daddr <= r_daddr + ADDR_W'(1);
            if (io_write && io_address == REG_LED)   r_leds  <= io_D[NUM_LEDS-1:0];
            if (io_write && io_address == REG_CTRL) begin
                r_cpu_reset <= io_D[CTRL_CPU_RESET];
                r_autoinc   <= io_D[CTRL_AUTOINC];
            end
        end
    end

    // RX holding register and sticky flags; a set in the same cycle as a clear wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_hold   <= '0;
            r_rx_valid  <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_rx_strobe) begin
                r_rx_hold  <= w_rx_byte;
                r_rx_valid <= 1'b1;
            end else if (w_rd_uart) begin
                r_rx_valid <= 1'b0;
            end
            if (w_rx_strobe && r_rx_valid && !w_rd_uart)   r_overrun <= 1'b1;
            else if (w_wr_status && io_D[ST_OVERRUN])      r_overrun <= 1'b0;
            if (w_rx_frame_err)                            r_frame_err <= 1'b1;
            else if (w_wr_status && io_D[ST_FRAME_ERR])    r_frame_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_discus_io_bridge.sv
// Self-checking bench for discus_io_bridge: external sync RAMs are emulated
// here, and a register-level model predicts every value read back.
module tb_discus_io_bridge;
    import discus_io_pkg::*;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 8;
    localparam int NUM_LEDS = 4;
    localparam int CPB      = 16;

    logic                clk, reset_n;
    logic                io_read, io_write;
    logic [2:0]          io_address;
    logic [DATA_W-1:0]   io_D, io_Q;
    logic                prog_we, data_we;
    logic [ADDR_W-1:0]   prog_addr, data_addr;
    logic [DATA_W-1:0]   prog_wdata, prog_rdata, data_wdata, data_rdata;
    logic                uart_rxd, uart_txd;
    logic [NUM_LEDS-1:0] leds;
    logic                cpu_reset;

    discus_io_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_LEDS(NUM_LEDS), .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk), .reset_n(reset_n), .io_read(io_read), .io_write(io_write),
        .io_address(io_address), .io_D(io_D), .io_Q(io_Q),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata), .prog_rdata(prog_rdata),
        .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .uart_rxd(uart_rxd), .uart_txd(uart_txd), .leds(leds), .cpu_reset(cpu_reset)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // external synchronous RAMs, 1-cycle read latency
    logic [7:0] pmem [256];
    logic [7:0] dmem [256];
    initial begin
        for (int i = 0; i < 256; i++) begin pmem[i] = 8'h00; dmem[i] = 8'h00; end
    end
    always @(posedge clk) begin
        if (prog_we) pmem[prog_addr] <= prog_wdata;
        if (data_we) dmem[data_addr] <= data_wdata;
        prog_rdata <= pmem[prog_addr];
        data_rdata <= dmem[data_addr];
    end

    // reference model state
    logic [7:0] m_paddr, m_daddr, m_rx_byte;
    logic [3:0] m_leds;
    logic       m_autoinc, m_cpu_reset, m_rx_valid, m_overrun, m_frame_err;
    logic [7:0] exp_pmem [256];
    logic [7:0] exp_dmem [256];
    logic [7:0] exp_q [$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_paddr = 0; m_daddr = 0; m_leds = 0; m_autoinc = 1; m_cpu_reset = 1;
        m_rx_valid = 0; m_overrun = 0; m_frame_err = 0; m_rx_byte = 0;
    endtask

    function automatic logic [7:0] exp_status(input logic busy);
        return {4'b0, m_frame_err, m_overrun, m_rx_valid, busy};
    endfunction

    function automatic logic [7:0] exp_reg(input logic [2:0] a);
        case (a)
            REG_PADDR:  return m_paddr;
            REG_DADDR:  return m_daddr;
            REG_LED:    return {4'b0, m_leds};
            REG_CTRL:   return {6'b0, m_autoinc, m_cpu_reset};
            REG_STATUS: return exp_status(1'b0);
            default:    return 8'h00;
        endcase
    endfunction

    // apply one register write to the model
    task automatic m_write(input logic [2:0] a, input logic [7:0] d);
        case (a)
            REG_PADDR:  m_paddr = d;
            REG_DADDR:  m_daddr = d;
            REG_PDATA:  begin exp_pmem[m_paddr] = d; if (m_autoinc) m_paddr = m_paddr + 8'd1; end
            REG_DDATA:  begin exp_dmem[m_daddr] = d; if (m_autoinc) m_daddr = m_daddr + 8'd1; end
            REG_STATUS: begin if (d[2]) m_overrun = 0; if (d[3]) m_frame_err = 0; end
            REG_LED:    m_leds = d[3:0];
            REG_CTRL:   begin m_cpu_reset = d[0]; m_autoinc = d[1]; end
            default:    ;
        endcase
    endtask

    // driver tasks
    task automatic io_wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        io_write = 1'b1; io_address = a; io_D = d;
        @(negedge clk);
        io_write = 1'b0;
        m_write(a, d);
    endtask

    task automatic io_rd(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        io_read = 1'b1; io_address = a;
        @(negedge clk);
        d = io_Q;
        io_read = 1'b0;
        if (a == REG_UART) m_rx_valid = 0;
    endtask

    task automatic rd_check(input string tag, input logic [2:0] a, input logic [7:0] exp);
        logic [7:0] v;
        io_rd(a, v);
        check(tag, v, exp);
    endtask

    // drive one serial frame, then a bit of idle line
    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            uart_rxd = frame[k];
            repeat (CPB) @(negedge clk);
        end
        uart_rxd = 1'b1;
        repeat (CPB) @(negedge clk);
        if (stop) begin
            if (m_rx_valid) m_overrun = 1;
            m_rx_valid = 1;
            m_rx_byte = b;
        end else begin
            m_frame_err = 1;
        end
    endtask

    // send b, try to overwrite it while busy, and sample every bit mid-period
    task automatic tx_frame(input logic [7:0] b, input logic [7:0] intruder);
        logic [9:0] frame;
        int lows;
        frame = {1'b1, b, 1'b0};
        io_wr(REG_UART, b);
        io_wr(REG_UART, intruder);
        repeat (CPB / 2 - 3) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("tx_bit%0d", k), uart_txd, frame[k]);
            if (k < 9) repeat (CPB) @(negedge clk);
        end
        rd_check("tx_busy_in_stop", REG_STATUS, exp_status(1'b1));
        repeat (CPB) @(negedge clk);
        rd_check("tx_busy_after", REG_STATUS, exp_status(1'b0));
        lows = 0;
        repeat (2 * CPB) begin
            @(negedge clk);
            if (!uart_txd) lows++;
        end
        check("tx_dropped_idle", lows, 0);
    endtask

    logic [7:0] v, b, start;
    int n;

    initial begin
        reset_n = 1'b0; io_read = 0; io_write = 0; io_address = 0; io_D = 0; uart_rxd = 1'b1;
        for (int i = 0; i < 256; i++) begin exp_pmem[i] = 0; exp_dmem[i] = 0; end
        m_reset();
        repeat (3) @(negedge clk);
        check("rst_txd", uart_txd, 1'b1);
        check("rst_cpu_reset", cpu_reset, m_cpu_reset);
        check("rst_leds", leds, m_leds);
        check("rst_io_q", io_Q, 8'h00);
        check("rst_we", {prog_we, data_we}, 2'b00);
        check("rst_addr", {prog_addr, data_addr}, {m_paddr, m_daddr});
        reset_n = 1'b1;
        rd_check("rst_ctrl", REG_CTRL, 8'h03);
        rd_check("rst_status", REG_STATUS, exp_reg(REG_STATUS));
        @(negedge clk);
        check("io_q_idle", io_Q, 8'h00);

        // auto-increment with wrap
        io_wr(REG_PADDR, 8'hFE);
        io_wr(REG_PDATA, 8'h11);
        io_wr(REG_PDATA, 8'h22);
        io_wr(REG_PDATA, 8'h33);
        repeat (3) @(negedge clk);
        check("pram_fe", pmem[8'hFE], exp_pmem[8'hFE]);
        check("pram_ff", pmem[8'hFF], exp_pmem[8'hFF]);
        check("pram_00", pmem[8'h00], exp_pmem[8'h00]);
        rd_check("paddr_wrap", REG_PADDR, exp_reg(REG_PADDR));

        // back-to-back random burst across the wrap point, read back by address
        start = 8'($urandom_range(250, 255));
        n = $urandom_range(4, 8);
        io_wr(REG_PADDR, start);
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            @(negedge clk);
            io_write = 1'b1; io_address = REG_PDATA; io_D = b;
            m_write(REG_PDATA, b);
            exp_q.push_back(b);
        end
        @(negedge clk);
        io_write = 1'b0;
        repeat (2) @(negedge clk);
        rd_check("burst_paddr", REG_PADDR, exp_reg(REG_PADDR));
        for (int i = 0; i < n; i++) begin
            io_wr(REG_PADDR, start + 8'(i));
            repeat (2) @(negedge clk);
            rd_check($sformatf("burst_rd%0d", i), REG_PDATA, exp_q.pop_front());
        end

        // no auto-increment on the data RAM
        io_wr(REG_CTRL, 8'h00);
        check("cpu_reset_off", cpu_reset, m_cpu_reset);
        io_wr(REG_DADDR, 8'h10);
        io_wr(REG_DDATA, 8'hAA);
        io_wr(REG_DDATA, 8'hAA);
        rd_check("daddr_hold", REG_DADDR, exp_reg(REG_DADDR));
        repeat (2) @(negedge clk);
        rd_check("ddata_rd", REG_DDATA, exp_dmem[m_daddr]);
        check("dram_11", dmem[8'h11], exp_dmem[8'h11]);
        rd_check("ctrl_rd", REG_CTRL, exp_reg(REG_CTRL));

        // LEDs, including a write colliding with a read
        repeat (3) begin
            b = 8'($urandom);
            io_wr(REG_LED, b);
            check("leds_port", leds, m_leds);
            rd_check("led_rd", REG_LED, exp_reg(REG_LED));
        end
        b = 8'($urandom);
        @(negedge clk);
        io_read = 1'b1; io_write = 1'b1; io_address = REG_LED; io_D = b;
        @(negedge clk);
        io_read = 1'b0; io_write = 1'b0;
        m_write(REG_LED, b);
        check("rw_collide_q", io_Q, 8'h00);
        check("rw_collide_led", leds, m_leds);

        // UART transmit
        tx_frame(8'h5A, 8'hFF);
        tx_frame(8'($urandom), 8'($urandom));

        // UART receive with overrun
        send_rx(8'h3C, 1'b1);
        send_rx(8'hC3, 1'b1);
        rd_check("ovr_status", REG_STATUS, exp_status(1'b0));
        rd_check("ovr_byte", REG_UART, m_rx_byte);
        rd_check("ovr_status2", REG_STATUS, exp_status(1'b0));
        io_wr(REG_STATUS, 8'h04);
        rd_check("ovr_cleared", REG_STATUS, exp_status(1'b0));

        repeat (4) begin
            send_rx(8'($urandom), 1'b1);
            rd_check("rx_status", REG_STATUS, exp_status(1'b0));
            rd_check("rx_byte", REG_UART, m_rx_byte);
        end

        // framing error and a start-bit glitch
        send_rx(8'($urandom), 1'b0);
        rd_check("ferr_status", REG_STATUS, exp_status(1'b0));
        uart_rxd = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        rd_check("glitch_status", REG_STATUS, exp_status(1'b0));
        io_wr(REG_STATUS, 8'h08);
        send_rx(8'($urandom), 1'b1);
        rd_check("post_glitch_byte", REG_UART, m_rx_byte);
        rd_check("post_glitch_status", REG_STATUS, exp_status(1'b0));

        // asynchronous reset in the middle of a transmit frame
        io_wr(REG_UART, 8'h00);
        repeat (3) @(negedge clk);
        check("mid_start_bit", uart_txd, 1'b0);
        #2 reset_n = 1'b0;
        #1 check("async_txd", uart_txd, 1'b1);
        check("async_cpu_reset", cpu_reset, 1'b1);
        m_reset();
        @(negedge clk);
        reset_n = 1'b1;
        rd_check("post_rst_ctrl", REG_CTRL, exp_reg(REG_CTRL));
        rd_check("post_rst_status", REG_STATUS, exp_status(1'b0));
        rd_check("post_rst_paddr", REG_PADDR, exp_reg(REG_PADDR));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
